// File: rtl/aiv_pixel_sampler_pkg.sv
// +----------------------------------------------------------------------+
// | Module      : aiv_pixel_sampler_pkg                                  |
// | Description : PAL 576i active-window timing defaults and helpers     |
// |               shared by the AIV pixel sampler.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package aiv_pixel_sampler_pkg;

   // Default source timing: 16 MHz BBC pixel sampled on a 96 MHz clock
   localparam int DEF_CLKS_PER_PIXEL = 6;
   localparam int DEF_SAMPLE_PHASE   = 3;
   localparam int DEF_H_START        = 1200;
   localparam int DEF_ACTIVE_PIXELS  = 640;
   localparam int DEF_V_START        = 23;
   localparam int DEF_ACTIVE_LINES   = 256;
   localparam int DEF_MAX_LINE_CLKS  = 7000;

   // Counter widths
   localparam int HCOUNT_W = 13;
   localparam int PHASE_W  = 3;
   localparam int PIX_W    = 10;
   localparam int LINE_W   = 9;

   typedef logic [HCOUNT_W-1:0] hcount_t;
   typedef logic [PHASE_W-1:0]  phase_t;
   typedef logic [PIX_W-1:0]    pix_t;
   typedef logic [LINE_W-1:0]   line_t;

   // Interlaced frame row: odd field on even rows, even field on odd rows
   function automatic logic [9:0] frame_y(input line_t active_line, input logic field_odd);
      return {active_line, ~field_odd};
   endfunction

endpackage

`default_nettype wire

// File: rtl/rising_edge_detect.sv
// +----------------------------------------------------------------------+
// | Module      : rising_edge_detect                                     |
// | Description : Single-cycle pulse on a 0->1 transition of in.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module rising_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic pulse
);

   logic in_d;

   // Remember previous input level
   always_ff @(posedge clk) begin
      if (reset) in_d <= 1'b0;
      else       in_d <= in;
   end

   assign pulse = in & ~in_d;

endmodule

`default_nettype wire

// File: rtl/aiv_pixel_sampler.sv
// +----------------------------------------------------------------------+
// | Module      : aiv_pixel_sampler                                      |
// | Description : Samples one RGB111 pixel per source pixel period in    |
// |               the PAL 576i active window and emits it with frame     |
// |               coordinates as a one-cycle strobe.                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module aiv_pixel_sampler
   import aiv_pixel_sampler_pkg::*;
#(
   parameter int CLKS_PER_PIXEL = DEF_CLKS_PER_PIXEL,
   parameter int SAMPLE_PHASE   = DEF_SAMPLE_PHASE,
   parameter int H_START        = DEF_H_START,
   parameter int ACTIVE_PIXELS  = DEF_ACTIVE_PIXELS,
   parameter int V_START        = DEF_V_START,
   parameter int ACTIVE_LINES   = DEF_ACTIVE_LINES,
   parameter int MAX_LINE_CLKS  = DEF_MAX_LINE_CLKS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       isFieldOdd,
   input  logic [2:0] rgb_in,
   output logic       pixel_valid,
   output logic [2:0] pixel_rgb,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       line_done,
   output logic       frame_start,
   output logic       locked
);

   localparam hcount_t H_START_C   = hcount_t'(H_START);
   localparam hcount_t MAX_CLKS_C  = hcount_t'(MAX_LINE_CLKS);
   localparam phase_t  PHASE_LAST  = phase_t'(CLKS_PER_PIXEL - 1);
   localparam phase_t  PHASE_SAMP  = phase_t'(SAMPLE_PHASE);
   localparam pix_t    PIX_END     = pix_t'(ACTIVE_PIXELS);
   localparam pix_t    PIX_LAST    = pix_t'(ACTIVE_PIXELS - 1);
   localparam line_t   LINE_FIRST  = line_t'(V_START);
   localparam line_t   LINE_END    = line_t'(V_START + ACTIVE_LINES);
   localparam line_t   LINE_SAT    = '1;

   logic    hs_edge;
   logic    vs_edge;
   hcount_t h_count;
   line_t   line_count;
   phase_t  phase;
   pix_t    pix_count;
   logic    field_odd;
   logic    line_active;
   logic    sample;

   rising_edge_detect u_hs_edge (
      .clk   (clk),
      .reset (reset),
      .in    (hsync),
      .pulse (hs_edge)
   );

   rising_edge_detect u_vs_edge (
      .clk   (clk),
      .reset (reset),
      .in    (vsync),
      .pulse (vs_edge)
   );

   // Clocks since line start; saturation marks a missing hsync
   always_ff @(posedge clk) begin
      if (reset)                     h_count <= '0;
      else if (hs_edge)              h_count <= '0;
      else if (h_count != MAX_CLKS_C) h_count <= h_count + 1'b1;
   end

   // Line index within the field; a coincident vsync edge wins over hsync
   always_ff @(posedge clk) begin
      if (reset)                                  line_count <= '0;
      else if (vs_edge)                           line_count <= '0;
      else if (hs_edge && line_count != LINE_SAT) line_count <= line_count + 1'b1;
   end

   // Field parity and lock: gained on vsync, lost when a line overruns
   always_ff @(posedge clk) begin
      if (reset) begin
         field_odd <= 1'b0;
         locked    <= 1'b0;
      end else if (vs_edge) begin
         field_odd <= isFieldOdd;
         locked    <= 1'b1;
      end else if (h_count == MAX_CLKS_C) begin
         locked    <= 1'b0;
      end
   end

   // Pixel phase and pixel index, realigned at every hsync edge
   always_ff @(posedge clk) begin
      if (reset || hs_edge) begin
         phase     <= '0;
         pix_count <= '0;
      end else if (h_count >= H_START_C) begin
         if (phase == PHASE_LAST) begin
            phase <= '0;
            if (pix_count != PIX_END) pix_count <= pix_count + 1'b1;
         end else begin
            phase <= phase + 1'b1;
         end
      end
   end

   assign line_active = locked && (line_count >= LINE_FIRST) && (line_count < LINE_END);

   // A mid-line hsync edge aborts the sample in the same cycle
   assign sample = line_active && (h_count >= H_START_C) && (pix_count < PIX_END)
                   && (phase == PHASE_SAMP) && !hs_edge;

   // Registered pixel strobe; coordinates and colour hold between strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_valid <= 1'b0;
         pixel_rgb   <= '0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         line_done   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pixel_valid <= sample;
         line_done   <= sample && (pix_count == PIX_LAST);
         frame_start <= vs_edge && isFieldOdd;
         if (sample) begin
            pixel_rgb <= rgb_in;
            pixel_x   <= pix_count;
            pixel_y   <= frame_y(line_count - LINE_FIRST, field_odd);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_aiv_pixel_sampler.sv
// +----------------------------------------------------------------------+
// | Module      : tb_aiv_pixel_sampler                                   |
// | Description : Directed self-checking bench for aiv_pixel_sampler.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_aiv_pixel_sampler;

   localparam logic [2:0] BG  = 3'b010;
   localparam logic [2:0] HOT = 3'b101;

   logic       clk = 1'b0;
   logic       reset;
   logic       hsync;
   logic       vsync;
   logic       isFieldOdd;
   logic [2:0] rgb_in;
   logic       pixel_valid;
   logic [2:0] pixel_rgb;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       line_done;
   logic       frame_start;
   logic       locked;

   int n_vec = 0;
   int n_err = 0;

   // Per-line observations
   int         n_str;
   int         first_hc;
   int         last_x;
   int         pos_err;
   int         y_err;
   int         ld_cnt;
   int         ld_x;
   int         fs_cnt;
   int         lk_end;
   logic [2:0] rgb_at [0:2];
   int         tot;

   aiv_pixel_sampler dut (
      .clk         (clk),
      .reset       (reset),
      .hsync       (hsync),
      .vsync       (vsync),
      .isFieldOdd  (isFieldOdd),
      .rgb_in      (rgb_in),
      .pixel_valid (pixel_valid),
      .pixel_rgb   (pixel_rgb),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .line_done   (line_done),
      .frame_start (frame_start),
      .locked      (locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One line: hsync (and optionally vsync) rises at the start, line lasts len clocks.
   // Loop index c equals the DUT line clock count at each falling edge.
   task automatic run_line(input int len, input bit vs, input bit odd, input int hot, input int exp_y);
      n_str = 0; first_hc = -1; last_x = -1; pos_err = 0; y_err = 0;
      ld_cnt = 0; ld_x = -1; fs_cnt = 0;
      rgb_at[0] = 3'b000; rgb_at[1] = 3'b000; rgb_at[2] = 3'b000;
      hsync = 1'b1;
      vsync = vs;
      if (vs) isFieldOdd = odd;
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         if (c == 0) begin
            hsync = 1'b0;
            vsync = 1'b0;
         end
         rgb_in = (c == hot) ? HOT : BG;
         if (pixel_valid) begin
            n_str++;
            if (first_hc < 0) first_hc = c;
            last_x = int'(pixel_x);
            if (c < 1204 || ((c - 1204) % 6) != 0 || int'(pixel_x) != (c - 1204) / 6) pos_err++;
            if (int'(pixel_y) != exp_y) y_err++;
            if (int'(pixel_x) < 3) rgb_at[int'(pixel_x)] = pixel_rgb;
         end
         if (line_done) begin
            ld_cnt++;
            ld_x = int'(pixel_x);
         end
         if (frame_start) fs_cnt++;
      end
      lk_end = int'(locked);
   endtask

   task automatic short_lines(input int n);
      for (int i = 0; i < n; i++) run_line(20, 1'b0, 1'b0, -1, 0);
   endtask

   initial begin
      reset = 1'b1; hsync = 1'b0; vsync = 1'b0; isFieldOdd = 1'b0; rgb_in = BG;
      repeat (4) @(negedge clk);
      chk("rst_valid", int'(pixel_valid), 0);
      chk("rst_x",     int'(pixel_x),     0);
      chk("rst_y",     int'(pixel_y),     0);
      chk("rst_rgb",   int'(pixel_rgb),   0);
      chk("rst_done",  int'(line_done),   0);
      chk("rst_fs",    int'(frame_start), 0);
      chk("rst_lock",  int'(locked),      0);
      reset = 1'b0;

      // hsync only: never locked, never strobes (lines 23/24 are full length)
      tot = 0;
      for (int i = 0; i < 22; i++) begin run_line(20, 1'b0, 1'b0, -1, 0); tot += n_str; end
      run_line(6144, 1'b0, 1'b0, -1, 0); tot += n_str;
      run_line(6144, 1'b0, 1'b0, -1, 0); tot += n_str;
      chk("nosync_strobes", tot, 0);
      chk("nosync_locked", lk_end, 0);

      // Odd field
      run_line(20, 1'b1, 1'b1, -1, 0);
      chk("odd_frame_start", fs_cnt, 1);
      chk("odd_locked", lk_end, 1);
      short_lines(22);
      run_line(6144, 1'b0, 1'b0, 1209, 0);
      chk("l23_count", n_str, 640);
      chk("l23_first_hc", first_hc, 1204);
      chk("l23_pos_err", pos_err, 0);
      chk("l23_last_x", last_x, 639);
      chk("l23_y_err", y_err, 0);
      chk("l23_done_cnt", ld_cnt, 1);
      chk("l23_done_x", ld_x, 639);
      chk("l23_rgb_x0", int'(rgb_at[0]), int'(BG));
      chk("l23_rgb_x1", int'(rgb_at[1]), int'(HOT));
      chk("l23_rgb_x2", int'(rgb_at[2]), int'(BG));
      chk("l23_x_hold", int'(pixel_x), 639);

      // Short line: hsync edge at hCount 3000
      run_line(3001, 1'b0, 1'b0, -1, 2);
      chk("short_count", n_str, 300);
      chk("short_last_x", last_x, 299);
      chk("short_done", ld_cnt, 0);
      chk("short_pos_err", pos_err, 0);
      run_line(6144, 1'b0, 1'b0, -1, 4);
      chk("l25_count", n_str, 640);
      chk("l25_first_hc", first_hc, 1204);
      chk("l25_y_err", y_err, 0);

      // Even field
      run_line(20, 1'b1, 1'b0, -1, 0);
      chk("even_frame_start", fs_cnt, 0);
      chk("even_locked", lk_end, 1);
      short_lines(23);
      run_line(6144, 1'b0, 1'b0, -1, 3);
      chk("e24_count", n_str, 640);
      chk("e24_y_err", y_err, 0);
      short_lines(253);
      run_line(6144, 1'b0, 1'b0, -1, 511);
      chk("e278_count", n_str, 640);
      chk("e278_y_err", y_err, 0);
      run_line(6144, 1'b0, 1'b0, -1, 0);
      chk("e279_count", n_str, 0);

      // Sync loss: line 24 runs to 7100 clocks without hsync
      run_line(20, 1'b1, 1'b1, -1, 0);
      short_lines(23);
      run_line(7100, 1'b0, 1'b0, -1, 2);
      chk("loss_l24_count", n_str, 640);
      chk("loss_locked", lk_end, 0);
      run_line(6144, 1'b0, 1'b0, -1, 4);
      chk("loss_l25_count", n_str, 0);
      chk("loss_l25_locked", lk_end, 0);
      run_line(20, 1'b1, 1'b1, -1, 0);
      short_lines(22);
      run_line(6144, 1'b0, 1'b0, -1, 0);
      chk("relock_count", n_str, 640);
      chk("relock_locked", lk_end, 1);

      // Reset mid-line clears everything on the next cycle
      run_line(1500, 1'b0, 1'b0, -1, 2);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_lock", int'(locked), 0);
      chk("mid_rst_x", int'(pixel_x), 0);
      chk("mid_rst_y", int'(pixel_y), 0);
      chk("mid_rst_valid", int'(pixel_valid), 0);
      reset = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
